// File: rtl/vx_commit_pending_tracker.sv
// vx_commit_pending_tracker
//
// Per-warp in-flight instruction tracker for the warp scheduler. Issue
// increments a warp's pending count and commit decrements it. The block
// reports drained, full and halted status per warp. It also raises sticky
// overflow and underflow protocol-error flags.
//
// Optional feature: define VX_COMMIT_PERF_EN to build a 64-bit counter of
// committed instructions. When the macro is undefined, perf_commits is
// tied to zero.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   issue_fire     per-slot issue strobe
//   issue_wid      per-slot issue warp id (slot i at [i*NW_WIDTH +: NW_WIDTH])
//   committed      per-slot retire strobe
//   committed_wid  per-slot retire warp id
//   halt           per-slot retired-instruction-is-halt (qualified by committed)
//   warp_restart   per-warp clear of halt state (priority over a same-cycle halt)
//   pending_cnt    per-warp registered in-flight count (warp w at [w*CTR_WIDTH +: CTR_WIDTH])
//   warp_drained   pending_cnt[w] == 0
//   warp_full      pending_cnt[w] > MAX - ISSUE_WIDTH
//   warp_halted    registered: halt pending for w and pending_cnt[w] == 0
//   err_overflow   sticky, count would have exceeded MAX
//   err_underflow  sticky, count would have gone below zero
//   perf_commits   total committed instructions (zero unless VX_COMMIT_PERF_EN)

module vx_commit_pending_tracker #(
    parameter int ISSUE_WIDTH  = 1,
    parameter int NUM_WARPS    = 4,
    parameter int CTR_WIDTH    = 8,
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ISSUE_WIDTH-1:0]          issue_fire,
    input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] issue_wid,
    input  logic [ISSUE_WIDTH-1:0]          committed,
    input  logic [ISSUE_WIDTH*NW_WIDTH-1:0] committed_wid,
    input  logic [ISSUE_WIDTH-1:0]          halt,
    input  logic [NUM_WARPS-1:0]            warp_restart,
    output logic [NUM_WARPS*CTR_WIDTH-1:0]  pending_cnt,
    output logic [NUM_WARPS-1:0]            warp_drained,
    output logic [NUM_WARPS-1:0]            warp_full,
    output logic [NUM_WARPS-1:0]            warp_halted,
    output logic                            err_overflow,
    output logic                            err_underflow,
    output logic [63:0]                     perf_commits
);

    localparam int CNT_W = $clog2(ISSUE_WIDTH + 1);
    localparam int SW    = CTR_WIDTH + 2;

    typedef logic signed [SW-1:0] sval_t;

    localparam sval_t MAX_S  = sval_t'((2 ** CTR_WIDTH) - 1);
    localparam sval_t FULL_S = sval_t'((2 ** CTR_WIDTH) - 1 - ISSUE_WIDTH);

    typedef enum logic {
        RUN       = 1'b0,
        HALT_PEND = 1'b1
    } halt_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CTR_WIDTH-1:0] cnt_q   [NUM_WARPS];
    logic [CTR_WIDTH-1:0] cnt_d   [NUM_WARPS];
    halt_state_t          state_q [NUM_WARPS];
    halt_state_t          state_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] halted_q;
    logic [NUM_WARPS-1:0] halted_d;

    // ------------------------------------------------------------------
    // Per-warp issue/commit counts and halt hits
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     inc [NUM_WARPS];
    logic [CNT_W-1:0]     dec [NUM_WARPS];
    logic [NUM_WARPS-1:0] halt_hit;

    // Out-of-range warp ids never match any tracked warp, so they drop out.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            inc[w]      = '0;
            dec[w]      = '0;
            halt_hit[w] = 1'b0;
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (issue_fire[i] &&
                    issue_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)) begin
                    inc[w] = inc[w] + CNT_W'(1);
                end
                if (committed[i] &&
                    committed_wid[i*NW_WIDTH +: NW_WIDTH] == NW_WIDTH'(w)) begin
                    dec[w] = dec[w] + CNT_W'(1);
                    if (halt[i]) begin
                        halt_hit[w] = 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Count update with saturation / clamping
    // ------------------------------------------------------------------
    sval_t                nxt [NUM_WARPS];
    logic [NUM_WARPS-1:0] ovf;
    logic [NUM_WARPS-1:0] unf;

    // Two guard bits give room for both the carry and the sign.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            nxt[w] = sval_t'(cnt_q[w]) + sval_t'(inc[w]) - sval_t'(dec[w]);
            ovf[w] = 1'b0;
            unf[w] = 1'b0;
            cnt_d[w] = nxt[w][CTR_WIDTH-1:0];
            if (nxt[w][SW-1]) begin
                unf[w]   = 1'b1;
                cnt_d[w] = '0;
            end else if (nxt[w] > MAX_S) begin
                ovf[w]   = 1'b1;
                cnt_d[w] = MAX_S[CTR_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-warp halt FSM (next state / halted output)
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            state_d[w]  = state_q[w];
            halted_d[w] = 1'b0;
            case (state_q[w])
                RUN: begin
                    if (!warp_restart[w] && halt_hit[w]) begin
                        state_d[w] = HALT_PEND;
                    end
                end
                HALT_PEND: begin
                    if (warp_restart[w]) begin
                        state_d[w] = RUN;
                    end else begin
                        halted_d[w] = (cnt_q[w] == '0);
                    end
                end
                default: state_d[w] = RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w]   <= '0;
                state_q[w] <= RUN;
            end
            halted_q      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w]   <= cnt_d[w];
                state_q[w] <= state_d[w];
            end
            halted_q      <= halted_d;
            err_overflow  <= err_overflow  | (|ovf);
            err_underflow <= err_underflow | (|unf);
        end
    end

    // ------------------------------------------------------------------
    // Status outputs derived from the registered count
    // ------------------------------------------------------------------
    always_comb begin
        pending_cnt  = '0;
        warp_drained = '0;
        warp_full    = '0;
        for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            pending_cnt[w*CTR_WIDTH +: CTR_WIDTH] = cnt_q[w];
            warp_drained[w] = (cnt_q[w] == '0);
            warp_full[w]    = (sval_t'(cnt_q[w]) > FULL_S);
        end
    end

    assign warp_halted = halted_q;

    // ------------------------------------------------------------------
    // Optional commit performance counter
    // ------------------------------------------------------------------
`ifdef VX_COMMIT_PERF_EN
    logic [63:0]      perf_q;
    logic [CNT_W-1:0] n_commit;

    always_comb begin
        n_commit = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            n_commit = n_commit + CNT_W'(committed[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_q + 64'(n_commit);
        end
    end

    assign perf_commits = perf_q;
`else
    assign perf_commits = '0;
`endif

endmodule

// File: tb/tb_vx_commit_pending_tracker.sv
// Scoreboard bench for vx_commit_pending_tracker (ISSUE_WIDTH=2,
// NUM_WARPS=4, CTR_WIDTH=3: MAX=7, full above 5).
module tb_vx_commit_pending_tracker;

    localparam int IW = 2;
    localparam int NW = 4;
    localparam int CW = 3;

`ifdef VX_COMMIT_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic            clk;
    logic            reset;
    logic [IW-1:0]   issue_fire;
    logic [IW*2-1:0] issue_wid;
    logic [IW-1:0]   committed;
    logic [IW*2-1:0] committed_wid;
    logic [IW-1:0]   halt;
    logic [NW-1:0]   warp_restart;
    logic [NW*CW-1:0] pending_cnt;
    logic [NW-1:0]   warp_drained;
    logic [NW-1:0]   warp_full;
    logic [NW-1:0]   warp_halted;
    logic            err_overflow;
    logic            err_underflow;
    logic [63:0]     perf_commits;

    vx_commit_pending_tracker #(
        .ISSUE_WIDTH (IW),
        .NUM_WARPS   (NW),
        .CTR_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .issue_fire    (issue_fire),
        .issue_wid     (issue_wid),
        .committed     (committed),
        .committed_wid (committed_wid),
        .halt          (halt),
        .warp_restart  (warp_restart),
        .pending_cnt   (pending_cnt),
        .warp_drained  (warp_drained),
        .warp_full     (warp_full),
        .warp_halted   (warp_halted),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .perf_commits  (perf_commits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned  tgt;
        bit           on_rst;
        string        nm;
        logic [11:0]  cnt;
        logic [3:0]   drn;
        logic [3:0]   full;
        logic [3:0]   hlt;
        logic         eo;
        logic         eu;
        logic [63:0]  perf;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] perf_exp = '0;
    logic        exp_eo   = 1'b0;
    logic        exp_eu   = 1'b0;

    task automatic chk(input string nm, input string fld, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    task automatic push(input string nm, input bit on_rst, input int c0, input int c1, input int c2,
                        input int c3, input logic [3:0] hl, input logic eo, input logic eu,
                        input logic [63:0] pf);
        exp_t e;
        int   c[4];
        c = '{c0, c1, c2, c3};
        e.tgt    = edge_cnt + 1;
        e.on_rst = on_rst;
        e.nm     = nm;
        e.hlt    = hl;
        e.eo     = eo;
        e.eu     = eu;
        e.perf   = PERF_ON ? pf : 64'd0;
        for (int w = 0; w < 4; w++) begin
            e.cnt[w*3 +: 3] = 3'(c[w]);
            e.drn[w]        = (c[w] == 0);
            e.full[w]       = (c[w] > 5);
        end
        sb.push_back(e);
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the state
    // expected after the following rising edge.
    task automatic cyc(input string nm, input logic [1:0] f, input int fw0, input int fw1,
                       input logic [1:0] c, input int cw0, input int cw1, input logic [1:0] h,
                       input logic [3:0] rs, input int c0, input int c1, input int c2, input int c3,
                       input logic [3:0] hl);
        issue_fire    = f;
        issue_wid     = {2'(fw1), 2'(fw0)};
        committed     = c;
        committed_wid = {2'(cw1), 2'(cw0)};
        halt          = h;
        warp_restart  = rs;
        perf_exp      = perf_exp + 64'(c[0]) + 64'(c[1]);
        push(nm, 1'b0, c0, c1, c2, c3, hl, exp_eo, exp_eu, perf_exp);
        @(negedge clk);
    endtask

    // Monitor: compares queued expectations after each rising clock edge,
    // and reset-tagged expectations right after reset asserts.
    initial begin
        bit is_clk;
        forever begin
            @(posedge clk or posedge reset);
            is_clk = clk;
            if (is_clk) edge_cnt++;
            #1;
            while (sb.size() > 0 &&
                   ((is_clk && !sb[0].on_rst && sb[0].tgt <= edge_cnt) || (!is_clk && sb[0].on_rst))) begin
                exp_t e;
                e = sb.pop_front();
                if (!e.on_rst && e.tgt != edge_cnt) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s.timing: checked at edge %0d expected edge %0d", e.nm, edge_cnt, e.tgt);
                end
                chk(e.nm, "pending_cnt",  64'(pending_cnt),   64'(e.cnt));
                chk(e.nm, "warp_drained", 64'(warp_drained),  64'(e.drn));
                chk(e.nm, "warp_full",    64'(warp_full),     64'(e.full));
                chk(e.nm, "warp_halted",  64'(warp_halted),   64'(e.hlt));
                chk(e.nm, "err_overflow", 64'(err_overflow),  64'(e.eo));
                chk(e.nm, "err_underflow",64'(err_underflow), 64'(e.eu));
                chk(e.nm, "perf_commits", perf_commits,       e.perf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got %0d pending expectations expected 0", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        issue_fire    = '0;
        issue_wid     = '0;
        committed     = '0;
        committed_wid = '0;
        halt          = '0;
        warp_restart  = '0;
        @(negedge clk);
        cyc("rst_hold", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        reset = 1'b0;
        for (int k = 0; k < 5; k++)
            cyc("idle", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);

        // warp 2: three issues then three commits
        cyc("w2_iss1", 2'b01, 2, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 1, 0, 4'h0);
        cyc("w2_iss2", 2'b01, 2, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 2, 0, 4'h0);
        cyc("w2_iss3", 2'b01, 2, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 3, 0, 4'h0);
        cyc("w2_com1", 2'b00, 0, 0, 2'b01, 2, 0, 2'b00, 4'h0, 0, 0, 2, 0, 4'h0);
        cyc("w2_com2", 2'b00, 0, 0, 2'b01, 2, 0, 2'b00, 4'h0, 0, 0, 1, 0, 4'h0);
        cyc("w2_com3", 2'b00, 0, 0, 2'b01, 2, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);

        // warp 1 to 5, net-zero cycle, dual issue on warp 0, full boundary
        cyc("w1_up2",  2'b11, 1, 1, 2'b00, 0, 0, 2'b00, 4'h0, 0, 2, 0, 0, 4'h0);
        cyc("w1_up4",  2'b11, 1, 1, 2'b00, 0, 0, 2'b00, 4'h0, 0, 4, 0, 0, 4'h0);
        cyc("w1_up5",  2'b01, 1, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 5, 0, 0, 4'h0);
        cyc("w1_net",  2'b01, 1, 0, 2'b01, 1, 0, 2'b00, 4'h0, 0, 5, 0, 0, 4'h0);
        cyc("w0_dual", 2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 2, 5, 0, 0, 4'h0);
        cyc("w1_full", 2'b01, 1, 0, 2'b00, 0, 0, 2'b00, 4'h0, 2, 6, 0, 0, 4'h0);
        cyc("w1_dn4",  2'b00, 0, 0, 2'b11, 1, 1, 2'b00, 4'h0, 2, 4, 0, 0, 4'h0);
        cyc("w1_dn2",  2'b00, 0, 0, 2'b11, 1, 1, 2'b00, 4'h0, 2, 2, 0, 0, 4'h0);
        cyc("w1_dn0",  2'b00, 0, 0, 2'b11, 1, 1, 2'b00, 4'h0, 2, 0, 0, 0, 4'h0);
        cyc("w0_dn0",  2'b00, 0, 0, 2'b11, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);

        // warp 3 halt, drain, restart; restart wins over a same-cycle halt
        cyc("w3_iss2", 2'b11, 3, 3, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 2, 4'h0);
        cyc("w3_halt", 2'b00, 0, 0, 2'b01, 3, 0, 2'b01, 4'h0, 0, 0, 0, 1, 4'h0);
        cyc("w3_last", 2'b00, 0, 0, 2'b01, 3, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        cyc("w3_hltd", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h8);
        cyc("w3_hold", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h8);
        cyc("w3_rst",  2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h8, 0, 0, 0, 0, 4'h0);
        cyc("w3_run",  2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        cyc("w3_iss1", 2'b01, 3, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 1, 4'h0);
        cyc("w3_hz",   2'b00, 0, 0, 2'b01, 3, 0, 2'b01, 4'h0, 0, 0, 0, 0, 4'h0);
        cyc("w3_hz1",  2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h8);
        cyc("w3_prio", 2'b01, 3, 0, 2'b01, 3, 0, 2'b01, 4'h8, 0, 0, 0, 0, 4'h0);
        cyc("w3_prio2",2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);

        // overflow on warp 0, drain, then underflow on warp 1
        cyc("ov_2",    2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 2, 0, 0, 0, 4'h0);
        cyc("ov_4",    2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 4, 0, 0, 0, 4'h0);
        cyc("ov_6",    2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 6, 0, 0, 0, 4'h0);
        exp_eo = 1'b1;
        cyc("ov_sat",  2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 7, 0, 0, 0, 4'h0);
        cyc("ov_dn5",  2'b00, 0, 0, 2'b11, 0, 0, 2'b00, 4'h0, 5, 0, 0, 0, 4'h0);
        cyc("ov_dn3",  2'b00, 0, 0, 2'b11, 0, 0, 2'b00, 4'h0, 3, 0, 0, 0, 4'h0);
        cyc("ov_dn1",  2'b00, 0, 0, 2'b11, 0, 0, 2'b00, 4'h0, 1, 0, 0, 0, 4'h0);
        cyc("ov_dn0",  2'b00, 0, 0, 2'b01, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        exp_eu = 1'b1;
        cyc("unf_w1",  2'b00, 0, 0, 2'b01, 1, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);

        // ten dual-commit cycles feed the performance counter
        for (int k = 0; k < 10; k++)
            cyc("perf",  2'b00, 0, 0, 2'b11, 1, 1, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        cyc("pre_rst", 2'b11, 2, 2, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 2, 0, 4'h0);

        // asynchronous reset between clock edges
        issue_fire = '0;
        committed  = '0;
        push("async_rst", 1'b1, 0, 0, 0, 0, 4'h0, 1'b0, 1'b0, 64'd0);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        perf_exp = '0;
        exp_eo   = 1'b0;
        exp_eu   = 1'b0;
        cyc("post_rst", 2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 4'h0);
        @(negedge clk);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_commit_pending_tracker.md
Name: vx_commit_pending_tracker

Overview:
- Consumer of the commit-to-scheduler bundle (committed, committed_wid, halt per issue slot); sits in the warp scheduler between issue and commit.
- Keeps a per-warp count of in-flight instructions. Increments on issue, decrements on commit.
- Reports per-warp drained and full status, plus a halted status once a halting warp has fully drained.
- Flags protocol errors: overflow and underflow.

Parameters:
- ISSUE_WIDTH, 1: issue/commit slots per cycle.
- NUM_WARPS, 4: warps tracked; NW_WIDTH = max(1, clog2(NUM_WARPS)).
- CTR_WIDTH, 8: pending counter width; MAX = 2^CTR_WIDTH-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- issue_fire  in  ISSUE_WIDTH  instruction issued on slot i this cycle.
- issue_wid  in  ISSUE_WIDTH x NW_WIDTH  warp id per issue slot.
- committed  in  ISSUE_WIDTH  instruction retired on slot i.
- committed_wid  in  ISSUE_WIDTH x NW_WIDTH  warp id per commit slot.
- halt  in  ISSUE_WIDTH  retired instruction on slot i is a halt (qualified by committed[i]).
- warp_restart  in  NUM_WARPS  clears halt state of warp w (wspawn/relaunch).
- pending_cnt  out  NUM_WARPS x CTR_WIDTH  registered in-flight count per warp.
- warp_drained  out  NUM_WARPS  pending_cnt[w]==0.
- warp_full  out  NUM_WARPS  pending_cnt[w] > MAX-ISSUE_WIDTH; scheduler must not issue to w.
- warp_halted  out  NUM_WARPS  halt seen for w and pending_cnt[w]==0.
- err_overflow  out  1  sticky.
- err_underflow  out  1  sticky.
- perf_commits  out  64  total committed instructions (see Optional Feature).

Behaviour:
- Reset (asynchronous assert, synchronous release) values:
  - all pending_cnt = 0
  - warp_drained = all ones
  - warp_full = 0
  - halt_req, warp_halted = 0
  - err_* = 0
  - perf_commits = 0
- Per warp per cycle:
  - inc[w] = number of slots i with issue_fire[i] && issue_wid[i]==w.
  - dec[w] = same count over committed/committed_wid.
  - Both are counts of width clog2(ISSUE_WIDTH+1).
- Update: next = pending + inc - dec, computed at CTR_WIDTH+2 bits signed. It takes effect on the next clock edge; all outputs are registered with 1-cycle latency.
- Simultaneous issue and commit on the same warp in the same cycle net out, e.g. inc=1, dec=1 leaves the count unchanged.
- Overflow: if next > MAX, the count saturates at MAX and err_overflow sets.
- Underflow: if next < 0, the count clamps to 0 and err_underflow sets.
- Error flags clear only on reset.
- warp_drained and warp_full are derived from the registered count, so they reflect state after the previous edge.
- Halt state:
  - halt_req[w] sets when any slot has committed && halt && committed_wid==w.
  - warp_halted[w] = halt_req[w] && pending_cnt[w]==0, registered.
  - If a halt commits in the same cycle the count reaches 0, warp_halted asserts the following cycle.
- warp_restart[w] clears halt_req[w] and warp_halted[w] next cycle; it has priority over a same-cycle halt set on w.
- Issue to a warp with halt_req set is a protocol violation. The count is still updated normally; there is no error flag for this.
- Out-of-range wid (>= NUM_WARPS) is ignored for both inc and dec.
- No internal state machine beyond the per-warp 2-state halt flag (RUN → HALT_PEND on halt; HALT_PEND → RUN on warp_restart). warp_halted is HALT_PEND && drained.

Optional Feature:
- Macro VX_COMMIT_PERF_EN.
- Defined: perf_commits is a 64-bit counter incremented each cycle by popcount(committed). It wraps modulo 2^64 and resets to 0.
- Undefined: perf_commits tied to 0 and no counter logic is instantiated.

Test Plan:
- Reset, then idle 5 cycles → pending_cnt all 0, warp_drained=4'b1111, warp_halted=0, err_*=0.
- Issue warp 2 on 3 consecutive cycles, then commit warp 2 ×3 → pending_cnt[2] goes 1,2,3,2,1,0 (1-cycle lag); warp_drained[2] re-asserts after the last commit.
- Same-cycle issue_fire and committed both on warp 1 with count 5 → count stays 5. Same cycle, ISSUE_WIDTH=2, both issue slots on warp 0 → +2.
- Warp 3 count 2; commit with halt=1; then final commit → warp_halted[3]=1 one cycle after the count hits 0. Pulse warp_restart[3] → warp_halted[3]=0 next cycle.
- CTR_WIDTH=2, issue warp 0 ×4 without commits → count saturates at 3, err_overflow=1, warp_full[0]=1. Commit on warp 1 at count 0 → err_underflow=1, count stays 0.
- With VX_COMMIT_PERF_EN, 10 cycles of committed=2'b11 → perf_commits=20. Assert reset mid-run → perf_commits=0 and all counts 0 immediately, without waiting for a clock edge.
